// File: rtl/benes_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// benes_cfg_ctrl
//
// Configuration sequencer for the 8x8 Benes datapath. The datapath has five
// registered stages of four 2x2 switches.
//
// Software writes per-stage switch controls into a shadow register. The write
// carrying cfg_last arms a commit. On the next start-of-frame beat, the shadow
// is copied into the active controls (sw_set) one stage per cycle. Each stage
// therefore switches exactly when the first beat of the new frame reaches it.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   configuration write handshake (accepted only in IDLE)
//   cfg_stage         target stage of the write
//   cfg_bits          switch controls for that stage (bit i -> switch i)
//   cfg_last          last write of a set; arms the commit
//   cfg_err           one-cycle pulse after an accepted write to a bad stage
//   din_valid/sof     beat entering stage 0 on the next cycle
//   sw_set            active controls; stage k at [k*N_SW +: N_SW]
//   dout_valid/sof    din_valid / din_sof&din_valid delayed N_STAGE+1 cycles
//   armed             committed set waiting for a frame boundary
//   commit_done       one-cycle pulse when the last stage has switched
// -----------------------------------------------------------------------------
module benes_cfg_ctrl #(
    parameter int N_STAGE = 5,
    parameter int N_SW    = 4,
    parameter int SIDX_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [SIDX_W-1:0]         cfg_stage,
    input  logic [N_SW-1:0]           cfg_bits,
    input  logic                      cfg_last,
    output logic                      cfg_err,
    input  logic                      din_valid,
    input  logic                      din_sof,
    output logic [N_STAGE*N_SW-1:0]   sw_set,
    output logic                      dout_valid,
    output logic                      dout_sof,
    output logic                      armed,
    output logic                      commit_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [SIDX_W-1:0]         cnt_q, cnt_d;
    logic [N_SW-1:0]           shadow_q [N_STAGE];
    logic [N_SW-1:0]           shadow_d [N_STAGE];
    logic [N_STAGE*N_SW-1:0]   sw_set_q, sw_set_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      commit_done_q, commit_done_d;
    logic [N_STAGE:0]          vld_dly_q;
    logic [N_STAGE:0]          sof_dly_q;

    logic wr_acc;
    logic wr_bad;
    logic do_load;

    assign wr_acc = cfg_valid && (state_q == S_IDLE);
    assign wr_bad = (cfg_stage >= SIDX_W'(N_STAGE));

    // Stage cnt_q loads in the cycle that sees the sof while ARMED (cnt_q is
    // 0 then) and in every SWEEP cycle after it. Stage k therefore loads at
    // the edge ending cycle G+k.
    assign do_load = ((state_q == S_ARMED) && din_valid && din_sof) ||
                     (state_q == S_SWEEP);

    always_comb begin
        // NOTE: every signal gets a default before the case. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        sw_set_d      = sw_set_q;
        cfg_err_d     = 1'b0;
        commit_done_d = 1'b0;

        if (wr_acc) begin
            for (int k = 0; k < N_STAGE; k++) begin
                if (!wr_bad && (cfg_stage == SIDX_W'(k))) begin
                    shadow_d[k] = cfg_bits;
                end
            end
            cfg_err_d = wr_bad;
            // A bad index still arms, so software always sees the commit end.
            if (cfg_last) begin
                state_d = S_ARMED;
            end
        end

        if (do_load) begin
            for (int k = 0; k < N_STAGE; k++) begin
                if (cnt_q == SIDX_W'(k)) begin
                    sw_set_d[k*N_SW +: N_SW] = shadow_q[k];
                end
            end
            if (cnt_q == SIDX_W'(N_STAGE - 1)) begin
                state_d       = S_IDLE;
                cnt_d         = '0;
                commit_done_d = 1'b1;
            end else begin
                state_d = S_SWEEP;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sw_set_q      <= '0;
            cfg_err_q     <= 1'b0;
            commit_done_q <= 1'b0;
            // NOTE: the shadow is a handful of flops, not a RAM. Resetting it
            // keeps "unwritten stage == last committed value" true after reset.
            for (int k = 0; k < N_STAGE; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments. Every flop
            // then samples the pre-edge values, independent of statement order.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sw_set_q      <= sw_set_d;
            cfg_err_q     <= cfg_err_d;
            commit_done_q <= commit_done_d;
            shadow_q      <= shadow_d;
        end
    end

    // Free-running beat tracker. It is one stage deeper than the switch
    // pipeline, so the output beat lines up with the last stage's registered
    // output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_dly_q <= '0;
            sof_dly_q <= '0;
        end else begin
            vld_dly_q <= {vld_dly_q[N_STAGE-1:0], din_valid};
            sof_dly_q <= {sof_dly_q[N_STAGE-1:0], din_valid & din_sof};
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign armed       = (state_q == S_ARMED);
    assign sw_set      = sw_set_q;
    assign cfg_err     = cfg_err_q;
    assign commit_done = commit_done_q;
    assign dout_valid  = vld_dly_q[N_STAGE];
    assign dout_sof    = sof_dly_q[N_STAGE];

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_benes_cfg_ctrl
//
// Directed bench for benes_cfg_ctrl.
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the
// same point, so every check sees the state of the current cycle.
// -----------------------------------------------------------------------------
module tb_benes_cfg_ctrl;

    localparam int N_STAGE = 5;
    localparam int N_SW    = 4;
    localparam int SIDX_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [SIDX_W-1:0]       cfg_stage;
    logic [N_SW-1:0]         cfg_bits;
    logic                    cfg_last;
    logic                    cfg_err;
    logic                    din_valid;
    logic                    din_sof;
    logic [N_STAGE*N_SW-1:0] sw_set;
    logic                    dout_valid;
    logic                    dout_sof;
    logic                    armed;
    logic                    commit_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    benes_cfg_ctrl #(
        .N_STAGE (N_STAGE),
        .N_SW    (N_SW),
        .SIDX_W  (SIDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_stage   (cfg_stage),
        .cfg_bits    (cfg_bits),
        .cfg_last    (cfg_last),
        .cfg_err     (cfg_err),
        .din_valid   (din_valid),
        .din_sof     (din_sof),
        .sw_set      (sw_set),
        .dout_valid  (dout_valid),
        .dout_sof    (dout_sof),
        .armed       (armed),
        .commit_done (commit_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; the write must be acceptable (IDLE).
    task automatic cfg_write(input logic [SIDX_W-1:0] st, input logic [N_SW-1:0] bits,
                             input logic last);
        check("ready_before_write", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_stage = st;
        cfg_bits  = bits;
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // The current cycle is G. Drive a sof here and follow the wavefront.
    // In cycle G+j, stages 0..j-1 hold the new value and the rest hold the old.
    task automatic run_sweep(input logic [19:0] old_sw, input logic [19:0] new_sw);
        logic [31:0] m;
        logic [19:0] exp_sw;
        check("armed_G", 32'(armed), 32'd1);
        check("sw_G", 32'(sw_set), 32'(old_sw));
        din_valid = 1'b1;
        din_sof   = 1'b1;
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        for (int j = 1; j <= N_STAGE; j++) begin
            m      = (32'h1 << (4 * j)) - 32'h1;
            exp_sw = (new_sw & m[19:0]) | (old_sw & ~m[19:0]);
            check("sw_wave", 32'(sw_set), 32'(exp_sw));
            check("armed_sweep", 32'(armed), 32'd0);
            check("commit_done_wave", 32'(commit_done), 32'(j == N_STAGE));
            check("ready_wave", 32'(cfg_ready), 32'(j == N_STAGE));
            check("dout_sof_early", 32'(dout_sof), 32'd0);
            if (j == N_STAGE) cfg_valid = 1'b0;
            tick();
        end
        // Cycle G+6
        check("dout_sof_G6", 32'(dout_sof), 32'd1);
        check("dout_valid_G6", 32'(dout_valid), 32'd1);
        check("commit_done_G6", 32'(commit_done), 32'd0);
        check("sw_final", 32'(sw_set), 32'(new_sw));
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_stage = '0;
        cfg_bits  = '0;
        cfg_last  = 1'b0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, then 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            check("idle_commit_done", 32'(commit_done), 32'd0);
            tick();
        end
        check("rst_sw_set", 32'(sw_set), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);

        // Full configuration of all five stages
        cfg_write(3'd0, 4'hF, 1'b0);
        cfg_write(3'd1, 4'h1, 1'b0);
        cfg_write(3'd2, 4'h2, 1'b0);
        cfg_write(3'd3, 4'h4, 1'b0);
        cfg_write(3'd4, 4'h8, 1'b1);
        check("armed_after_last", 32'(armed), 32'd1);
        check("ready_armed", 32'(cfg_ready), 32'd0);
        check("no_err_valid", 32'(cfg_err), 32'd0);
        // Non-sof beats while ARMED do nothing.
        din_valid = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        check("armed_nonsof", 32'(armed), 32'd1);
        check("sw_nonsof", 32'(sw_set), 32'h0);
        run_sweep(20'h00000, 20'h8421F);

        // Partial update: stage 2 only
        tick();
        cfg_write(3'd2, 4'hA, 1'b1);
        run_sweep(20'h8421F, 20'h84A1F);

        // Invalid stage index: pulse cfg_err, still arm, change nothing
        tick();
        cfg_write(3'd6, 4'h5, 1'b1);
        check("err_pulse", 32'(cfg_err), 32'd1);
        check("armed_bad", 32'(armed), 32'd1);
        tick();
        check("err_cleared", 32'(cfg_err), 32'd0);
        run_sweep(20'h84A1F, 20'h84A1F);

        // cfg_last write arrives with a sof in the same cycle; cfg_valid is
        // then held high through ARMED and SWEEP.
        tick();
        check("ready_simul", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_stage = 3'd0;
        cfg_bits  = 4'h3;
        cfg_last  = 1'b1;
        din_valid = 1'b1;
        din_sof   = 1'b1;
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        cfg_bits  = 4'h5;  // would corrupt stage 0 if accepted
        check("armed_simul", 32'(armed), 32'd1);
        check("sw_simul", 32'(sw_set), 32'h84A1F);
        for (int i = 0; i < 6; i++) begin
            check("ready_held", 32'(cfg_ready), 32'd0);
            tick();
        end
        run_sweep(20'h84A1F, 20'h84A13);

        // Reset in cycle G+2 of a sweep
        tick();
        cfg_write(3'd1, 4'h7, 1'b1);
        din_valid = 1'b1;
        din_sof   = 1'b1;
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_sw", 32'(sw_set), 32'h0);
        check("midrst_ready", 32'(cfg_ready), 32'd1);
        check("midrst_armed", 32'(armed), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_commit", 32'(commit_done), 32'd0);
            check("midrst_sw_hold", 32'(sw_set), 32'h0);
            tick();
        end
        cfg_write(3'd3, 4'hC, 1'b1);
        run_sweep(20'h00000, 20'h0C000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/benes_cfg_ctrl.md
Name: benes_cfg_ctrl

Overview:
- Configuration sequencer for the 8x8 Benes datapath.
- The datapath is five registered stages of four 2x2 switches each. Every stage adds one cycle of latency, and each switch has one cross/straight control bit.
- The block collects a new per-stage switch configuration into a shadow register from a software-facing valid/ready port. It then applies the configuration as a wavefront at a frame boundary, so that every stage switches exactly when the first beat of the new frame reaches it.
- It also tracks valid/sof through the pipeline and reports commit completion.

Parameters:
- N_STAGE, 5, number of Benes stages (2*log2(8)-1).
- N_SW, 4, switches per stage; width of one stage control word.
- SIDX_W, 3, width of the stage index; must satisfy 2**SIDX_W >= N_STAGE.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- cfg_valid, input, 1, a configuration write is offered.
- cfg_ready, output, 1, a configuration write can be accepted.
- cfg_stage, input, SIDX_W, target stage index of the write.
- cfg_bits, input, N_SW, switch controls for that stage; bit i drives switch i.
- cfg_last, input, 1, final write of a configuration set; arms the commit.
- cfg_err, output, 1, one-cycle pulse: the accepted write had cfg_stage >= N_STAGE.
- din_valid, input, 1, a beat enters stage 0 on the next cycle.
- din_sof, input, 1, the beat is the first beat of a frame; qualified by din_valid.
- sw_set, output, N_STAGE*N_SW, active controls; stage k occupies bits [k*N_SW +: N_SW].
- dout_valid, output, 1, din_valid delayed by N_STAGE+1 cycles.
- dout_sof, output, 1, din_sof&din_valid delayed by N_STAGE+1 cycles.
- armed, output, 1, a committed configuration is waiting for a frame boundary.
- commit_done, output, 1, one-cycle pulse when the last stage has switched.

Behaviour:
- Reset values:
  - sw_set = 0 (all switches straight); the shadow register is also 0.
  - cfg_ready = 1; cfg_err, dout_valid, dout_sof, armed and commit_done = 0.
  - State = IDLE; the sweep counter = 0; the delay lines are cleared.
- Reset asserted mid-SWEEP abandons the wavefront. Stages already switched revert to 0.
- States:
  - IDLE: cfg_ready=1, armed=0.
  - ARMED: cfg_ready=0, armed=1.
  - SWEEP: cfg_ready=0, armed=0.
- Write acceptance (IDLE only):
  - A write is accepted when cfg_valid & cfg_ready.
  - Valid index: shadow[cfg_stage] <= cfg_bits.
  - Invalid index (cfg_stage >= N_STAGE): the shadow is unchanged and cfg_err=1 on the next cycle.
  - Unwritten stages keep their previous shadow value, which equals the last committed value.
- IDLE -> ARMED: an accepted write with cfg_last=1, including one with an invalid index. armed=1 from the next cycle.
- ARMED -> SWEEP at cycle G, the first cycle in ARMED with din_valid & din_sof:
  - The beat enters stage 0 at G+1.
  - Stage k's sw_set field loads shadow[k] at the edge ending cycle G+k, so it is visible in cycle G+k+1.
  - The counter runs 0..N_STAGE-1.
  - Non-sof beats in ARMED do nothing.
- SWEEP -> IDLE:
  - When the counter reaches N_STAGE-1, the last stage loads.
  - commit_done=1 in cycle G+N_STAGE.
  - cfg_ready=1 from cycle G+N_STAGE.
- Stage fields not yet reached by the wavefront hold their old values. sw_set changes only through a sweep or reset.
- Sof beats seen while in IDLE or SWEEP cause no reconfiguration.
- Simultaneous events:
  - A cfg_last write and din_sof in the same cycle in IDLE: the write is accepted and the sof is ignored for commit. Only a later sof commits.
  - A sof arriving during SWEEP does not restart the sweep.
- Delay lines: dout_valid/dout_sof form a free-running shift register of depth N_STAGE+1, independent of the FSM. The output beat therefore aligns with the last stage's registered output.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then idle for 10 cycles -> sw_set=20'h0, cfg_ready=1, armed=0, no commit_done.
- Write stages 0..4 with 4'hF,4'h1,4'h2,4'h4,4'h8 (cfg_last on stage 4), then din_sof in cycle G -> armed=1 until G.
  - Stage k field changes in cycle G+k+1; until then each field holds its old value.
  - Final sw_set=20'h8421F.
  - commit_done pulse in G+5.
  - dout_sof in G+6.
- Write only stage 2=4'hA with cfg_last after the previous scenario, then sof -> final sw_set=20'h84A1F; only bits [11:8] change.
- Write with cfg_stage=6, cfg_last=1 -> cfg_err pulse one cycle later, shadow unchanged, armed=1. After sof, the sweep completes with no change to sw_set.
- cfg_valid held high during ARMED and SWEEP -> cfg_ready=0 and no write is accepted. A sof in the same cycle as the cfg_last write does not commit; the next sof does.
- Assert rst in cycle G+2 of a sweep -> sw_set=0, state IDLE, and no commit_done.
  - After release, a new commit works normally.
